// File: rtl/mem_port_arbiter.sv
// Two-requester, single-port memory arbiter. Fetch (read-only) and
// load/store requesters share one downstream port, one transaction in flight.
module mem_port_arbiter #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_req_valid,
    output logic                i_req_ready,
    input  logic [ADDR_W-1:0]   i_req_addr,
    output logic                i_resp_valid,
    input  logic                i_resp_ready,
    output logic [DATA_W-1:0]   i_resp_rdata,
    input  logic                d_req_valid,
    output logic                d_req_ready,
    input  logic                d_req_we,
    input  logic [ADDR_W-1:0]   d_req_addr,
    input  logic [DATA_W-1:0]   d_req_wdata,
    input  logic [DATA_W/8-1:0] d_req_wmask,
    output logic                d_resp_valid,
    input  logic                d_resp_ready,
    output logic [DATA_W-1:0]   d_resp_rdata,
    output logic                m_req_valid,
    input  logic                m_req_ready,
    output logic                m_req_we,
    output logic [ADDR_W-1:0]   m_req_addr,
    output logic [DATA_W-1:0]   m_req_wdata,
    output logic [DATA_W/8-1:0] m_req_wmask,
    input  logic                m_resp_valid,
    output logic                m_resp_ready,
    input  logic [DATA_W-1:0]   m_resp_rdata,
    output logic                busy,
    output logic                owner_d
);

    localparam int MASK_W = DATA_W / 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic                grant_q, grant_d;     // 1 = data port owns / owned last
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [MASK_W-1:0]   wmask_q, wmask_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;

    // Round-robin grant: on a tie the port not granted last wins. Depends only
    // on state and requester valids, never on downstream inputs.
    always_comb begin
        i_req_ready = 1'b0;
        d_req_ready = 1'b0;
        if (state_q == ST_IDLE) begin
            i_req_ready = i_req_valid && (!d_req_valid || grant_q);
            d_req_ready = d_req_valid && (!i_req_valid || !grant_q);
        end
    end

    // Next-state and latched-field logic.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wmask_d = wmask_q;
        rdata_d = rdata_q;
        unique case (state_q)
            ST_IDLE: begin
                if (i_req_ready) begin
                    state_d = ST_REQ;
                    grant_d = 1'b0;
                    we_d    = 1'b0;
                    addr_d  = i_req_addr;
                    wdata_d = '0;
                    wmask_d = '0;
                end else if (d_req_ready) begin
                    state_d = ST_REQ;
                    grant_d = 1'b1;
                    we_d    = d_req_we;
                    addr_d  = d_req_addr;
                    wdata_d = d_req_wdata;
                    wmask_d = d_req_wmask;
                end
            end
            ST_REQ: begin
                if (m_req_ready) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (m_resp_valid) begin
                    state_d = ST_RESP;
                    rdata_d = m_resp_rdata;
                end
            end
            ST_RESP: begin
                if (grant_q ? d_resp_ready : i_resp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and latched fields; reset drops any in-flight transaction.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            grant_q <= 1'b1;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wmask_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wmask_q <= wmask_d;
            rdata_q <= rdata_d;
        end
    end

    // Outputs decode directly from registered state.
    always_comb begin
        m_req_valid  = (state_q == ST_REQ);
        m_resp_ready = (state_q == ST_WAIT);
        i_resp_valid = (state_q == ST_RESP) && !grant_q;
        d_resp_valid = (state_q == ST_RESP) && grant_q;
        i_resp_rdata = rdata_q;
        d_resp_rdata = rdata_q;
        m_req_we     = we_q;
        m_req_addr   = addr_q;
        m_req_wdata  = wdata_q;
        m_req_wmask  = wmask_q;
        busy         = (state_q != ST_IDLE);
        owner_d      = grant_q;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed testbench for mem_port_arbiter. Inputs change right after the
// falling edge; outputs are sampled 1 time unit later.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req_valid, i_req_ready, i_resp_valid, i_resp_ready;
    logic [63:0] i_req_addr, i_resp_rdata;
    logic        d_req_valid, d_req_ready, d_req_we, d_resp_valid, d_resp_ready;
    logic [63:0] d_req_addr, d_req_wdata, d_resp_rdata;
    logic [7:0]  d_req_wmask;
    logic        m_req_valid, m_req_ready, m_req_we, m_resp_valid, m_resp_ready;
    logic [63:0] m_req_addr, m_req_wdata, m_resp_rdata;
    logic [7:0]  m_req_wmask;
    logic        busy, owner_d;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(64), .DATA_W(64)) dut (
        .clk(clk), .rst(rst),
        .i_req_valid(i_req_valid), .i_req_ready(i_req_ready), .i_req_addr(i_req_addr),
        .i_resp_valid(i_resp_valid), .i_resp_ready(i_resp_ready), .i_resp_rdata(i_resp_rdata),
        .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_we(d_req_we),
        .d_req_addr(d_req_addr), .d_req_wdata(d_req_wdata), .d_req_wmask(d_req_wmask),
        .d_resp_valid(d_resp_valid), .d_resp_ready(d_resp_ready), .d_resp_rdata(d_resp_rdata),
        .m_req_valid(m_req_valid), .m_req_ready(m_req_ready), .m_req_we(m_req_we),
        .m_req_addr(m_req_addr), .m_req_wdata(m_req_wdata), .m_req_wmask(m_req_wmask),
        .m_resp_valid(m_resp_valid), .m_resp_ready(m_resp_ready), .m_resp_rdata(m_resp_rdata),
        .busy(busy), .owner_d(owner_d)
    );

    task automatic step();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        i_req_valid = 0; i_req_addr = '0; i_resp_ready = 0;
        d_req_valid = 0; d_req_we = 0; d_req_addr = '0; d_req_wdata = '0; d_req_wmask = '0;
        d_resp_ready = 0; m_req_ready = 0; m_resp_valid = 0; m_resp_rdata = '0;
    endtask

    task automatic pulse_reset();
        step(); idle_inputs(); rst = 1;
        step(); step(); rst = 0;
    endtask

    task automatic test_reset();
        rst = 1; idle_inputs();
        step(); step(); rst = 0; #1;
        if (busy !== 1'b0) begin $display("FAIL reset_busy: got %b exp 0", busy); n_err++; end n_cmp++;
        if (owner_d !== 1'b1) begin $display("FAIL reset_owner: got %b exp 1", owner_d); n_err++; end n_cmp++;
        if ({m_req_valid, m_resp_ready, i_resp_valid, d_resp_valid, i_req_ready, d_req_ready} !== 6'b0) begin
            $display("FAIL reset_valids: got %b exp 000000",
                     {m_req_valid, m_resp_ready, i_resp_valid, d_resp_valid, i_req_ready, d_req_ready}); n_err++;
        end n_cmp++;
        if ({m_req_we, m_req_addr, m_req_wdata, m_req_wmask, i_resp_rdata} !== '0) begin
            $display("FAIL reset_fields: addr %h wdata %h mask %h rdata %h exp all 0",
                     m_req_addr, m_req_wdata, m_req_wmask, i_resp_rdata); n_err++;
        end n_cmp++;
        $display("reset: busy=%b owner_d=%b", busy, owner_d);
    endtask

    task automatic test_single_fetch();
        step(); i_req_valid = 1; i_req_addr = 64'h1000; m_req_ready = 1; #1;   // C0
        if (i_req_ready !== 1'b1) begin $display("FAIL fetch_c0_ready: got %b exp 1", i_req_ready); n_err++; end n_cmp++;
        step(); i_req_valid = 0; #1;                                           // C1
        if (m_req_valid !== 1'b1 || m_req_addr !== 64'h1000 || m_req_we !== 1'b0) begin
            $display("FAIL fetch_c1_req: valid %b addr %h we %b exp 1 1000 0", m_req_valid, m_req_addr, m_req_we); n_err++;
        end n_cmp++;
        if (owner_d !== 1'b0) begin $display("FAIL fetch_owner: got %b exp 0", owner_d); n_err++; end n_cmp++;
        step(); m_resp_valid = 1; m_resp_rdata = 64'h13; #1;                    // C2
        if (m_resp_ready !== 1'b1) begin $display("FAIL fetch_c2_mresp_ready: got %b exp 1", m_resp_ready); n_err++; end n_cmp++;
        step(); m_resp_valid = 0; i_resp_ready = 1; #1;                        // C3
        if (i_resp_valid !== 1'b1 || i_resp_rdata !== 64'h13 || d_resp_valid !== 1'b0) begin
            $display("FAIL fetch_c3_resp: ivalid %b rdata %h dvalid %b exp 1 13 0", i_resp_valid, i_resp_rdata, d_resp_valid); n_err++;
        end n_cmp++;
        step(); i_resp_ready = 0; #1;                                          // C4
        if (busy !== 1'b0) begin $display("FAIL fetch_c4_busy: got %b exp 0", busy); n_err++; end n_cmp++;
        $display("fetch addr=1000 rdata=%h", i_resp_rdata);
    endtask

    task automatic test_store_load();
        logic [63:0] mem_word = 64'h0;
        for (int k = 0; k < 2; k++) begin
            logic is_store = (k == 0);
            step(); d_req_valid = 1; d_req_we = is_store; d_req_addr = 64'h2008;
            d_req_wdata = is_store ? 64'hDEADBEEF : 64'h0; d_req_wmask = is_store ? 8'h0F : 8'h00;
            m_req_ready = 1; #1;
            if (d_req_ready !== 1'b1) begin $display("FAIL sl%0d_d_ready: got %b exp 1", k, d_req_ready); n_err++; end n_cmp++;
            step(); d_req_valid = 0; #1;
            if (m_req_we !== is_store || m_req_addr !== 64'h2008 || m_req_wmask !== (is_store ? 8'h0F : 8'h00)) begin
                $display("FAIL sl%0d_mreq: we %b addr %h mask %h exp %b 2008 %h", k, m_req_we, m_req_addr, m_req_wmask,
                         is_store, is_store ? 8'h0F : 8'h00); n_err++;
            end n_cmp++;
            if (is_store && m_req_wdata !== 64'hDEADBEEF) begin
                $display("FAIL sl_wdata: got %h exp deadbeef", m_req_wdata); n_err++;
            end
            if (is_store) n_cmp++;
            if (m_req_we) mem_word = m_req_wdata;
            step(); m_resp_valid = 1; m_resp_rdata = is_store ? 64'h0 : mem_word;
            step(); m_resp_valid = 0; d_resp_ready = 1; #1;
            if (d_resp_valid !== 1'b1 || i_resp_valid !== 1'b0) begin
                $display("FAIL sl%0d_resp_valid: d %b i %b exp 1 0", k, d_resp_valid, i_resp_valid); n_err++;
            end n_cmp++;
            if (!is_store && d_resp_rdata !== 64'hDEADBEEF) begin
                $display("FAIL sl_load_rdata: got %h exp deadbeef", d_resp_rdata); n_err++;
            end
            if (!is_store) n_cmp++;
            step(); d_resp_ready = 0;
            $display("%s addr=2008 data=%h", is_store ? "store" : "load", is_store ? 64'hDEADBEEF : d_resp_rdata);
        end
    endtask

    task automatic test_tie();
        logic        exp_own [3] = '{1'b0, 1'b1, 1'b0};
        logic [63:0] exp_addr[3] = '{64'h100, 64'h200, 64'h100};
        pulse_reset();
        i_req_valid = 1; i_req_addr = 64'h100;
        d_req_valid = 1; d_req_we = 0; d_req_addr = 64'h200;
        i_resp_ready = 1; d_resp_ready = 1; m_req_ready = 1; #1;
        for (int g = 0; g < 3; g++) begin
            if (i_req_ready !== !exp_own[g] || d_req_ready !== exp_own[g]) begin
                $display("FAIL tie%0d_grant: iready %b dready %b exp %b %b", g, i_req_ready, d_req_ready,
                         !exp_own[g], exp_own[g]); n_err++;
            end n_cmp++;
            step(); if (exp_own[g]) d_req_valid = 0; #1;
            if (owner_d !== exp_own[g] || m_req_addr !== exp_addr[g]) begin
                $display("FAIL tie%0d_owner: owner %b addr %h exp %b %h", g, owner_d, m_req_addr, exp_own[g], exp_addr[g]); n_err++;
            end n_cmp++;
            step(); m_resp_valid = 1; m_resp_rdata = 64'(g);
            step(); m_resp_valid = 0; #1;
            if (i_resp_valid !== !exp_own[g] || d_resp_valid !== exp_own[g]) begin
                $display("FAIL tie%0d_resp: i %b d %b exp %b %b", g, i_resp_valid, d_resp_valid, !exp_own[g], exp_own[g]); n_err++;
            end n_cmp++;
            step(); #1;
            $display("tie grant %0d owner_d=%b", g, exp_own[g]);
        end
        step(); idle_inputs();
    endtask

    task automatic test_backpressure();
        int k;
        bit seen_idle = 0;
        pulse_reset();
        step(); d_req_valid = 1; d_req_we = 1; d_req_addr = 64'h3000; d_req_wdata = 64'h55AA; d_req_wmask = 8'hFF; #1;
        if (d_req_ready !== 1'b1) begin $display("FAIL bp_grant: got %b exp 1", d_req_ready); n_err++; end n_cmp++;
        for (k = 1; k <= 20 && !seen_idle; k++) begin
            step();
            d_req_valid  = 0;
            i_req_valid  = 1; i_req_addr = 64'h9000;
            m_req_ready  = (k == 4);
            m_resp_valid = (k == 7);
            d_resp_ready = (k == 10);
            #1;
            if (!busy) seen_idle = 1;
            else begin
                if (i_req_ready !== 1'b0 || m_req_addr !== 64'h3000 || m_req_wdata !== 64'h55AA || m_req_wmask !== 8'hFF) begin
                    $display("FAIL bp_hold_k%0d: iready %b addr %h wdata %h mask %h exp 0 3000 55aa ff",
                             k, i_req_ready, m_req_addr, m_req_wdata, m_req_wmask); n_err++;
                end n_cmp++;
            end
        end
        if (!seen_idle || k - 1 != 11) begin
            $display("FAIL bp_total: idle at cycle %0d (seen %b) exp 11", k - 1, seen_idle); n_err++;
        end n_cmp++;
        if (i_req_ready !== 1'b1) begin $display("FAIL bp_next_grant: got %b exp 1", i_req_ready); n_err++; end n_cmp++;
        $display("backpressure store addr=3000 idle after %0d cycles", k - 1);
        step(); idle_inputs();
    endtask

    task automatic test_reset_wait();
        bit stray = 0;
        pulse_reset();
        i_req_valid = 1; i_req_addr = 64'h4000; m_req_ready = 1;
        step(); i_req_valid = 0;
        step(); #1;
        if (m_resp_ready !== 1'b1) begin $display("FAIL rw_in_wait: got %b exp 1", m_resp_ready); n_err++; end n_cmp++;
        rst = 1;
        step(); rst = 0; #1;
        if ({busy, m_req_valid, m_resp_ready, i_resp_valid, d_resp_valid} !== 5'b0 || owner_d !== 1'b1) begin
            $display("FAIL rw_after_reset: busy/valids %b owner %b exp 00000 1",
                     {busy, m_req_valid, m_resp_ready, i_resp_valid, d_resp_valid}, owner_d); n_err++;
        end n_cmp++;
        i_resp_ready = 1;
        for (int c = 0; c < 3; c++) begin step(); #1; if (i_resp_valid) stray = 1; end
        if (stray) begin $display("FAIL rw_stray_resp: got 1 exp 0"); n_err++; end n_cmp++;
        step(); i_req_valid = 1; i_req_addr = 64'h4008; #1;
        step(); i_req_valid = 0; #1;
        if (m_req_addr !== 64'h4008) begin $display("FAIL rw_refetch_addr: got %h exp 4008", m_req_addr); n_err++; end n_cmp++;
        step(); m_resp_valid = 1; m_resp_rdata = 64'h77;
        step(); m_resp_valid = 0; #1;
        if (i_resp_valid !== 1'b1 || i_resp_rdata !== 64'h77) begin
            $display("FAIL rw_refetch_resp: valid %b rdata %h exp 1 77", i_resp_valid, i_resp_rdata); n_err++;
        end n_cmp++;
        step(); #1;
        $display("reset-in-wait then fetch addr=4008 rdata=77");
        idle_inputs();
    endtask

    task automatic test_spurious();
        step(); m_resp_valid = 1; m_resp_rdata = 64'hBAD;
        for (int c = 0; c < 3; c++) begin
            step(); #1;
            if ({m_resp_ready, i_resp_valid, d_resp_valid, busy} !== 4'b0) begin
                $display("FAIL spurious_c%0d: mready/ivalid/dvalid/busy %b exp 0000", c,
                         {m_resp_ready, i_resp_valid, d_resp_valid, busy}); n_err++;
            end n_cmp++;
        end
        m_resp_valid = 0;
        $display("spurious reply in IDLE ignored");
    endtask

    initial begin
        test_reset();
        test_single_fetch();
        test_store_load();
        test_tie();
        test_backpressure();
        test_reset_wait();
        test_spurious();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
